// File: rtl/puf_pkg.sv
// Shared constants for the arbiter-PUF race sampler: FSM state encodings,
// counter width helper and parameter legality limits.
package puf_pkg;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_RELAX = 2'd1;
  localparam logic [ST_W-1:0] ST_FIRE  = 2'd2;
  localparam logic [ST_W-1:0] ST_DONE  = 2'd3;

  localparam int unsigned MIN_N_REP         = 1;
  localparam int unsigned MIN_SETTLE_CYCLES = 4;
  localparam int unsigned MIN_RELAX_CYCLES  = 1;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer with synchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/puf_race_sampler.sv
// Arbiter-PUF launch controller: fires the delay line N_REP times per challenge,
// majority-votes the synchronized arbiter samples and returns bit + stability.
module puf_race_sampler
  import puf_pkg::*;
#(
  parameter int unsigned C_LENGTH      = 32,
  parameter int unsigned N_REP         = 15,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned RELAX_CYCLES  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            chal_valid,
  output logic                            chal_ready,
  input  logic [C_LENGTH-1:0]             chal_data,
  output logic [C_LENGTH-1:0]             challenge,
  output logic                            ipulse,
  input  logic                            arb_in,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic                            resp_bit,
  output logic [cnt_width(N_REP)-1:0]     resp_ones,
  output logic                            resp_stable,
  output logic                            busy
);

  localparam int unsigned CNT_W   = cnt_width(N_REP);
  localparam int unsigned CYC_MAX = (SETTLE_CYCLES > RELAX_CYCLES) ? SETTLE_CYCLES : RELAX_CYCLES;
  localparam int unsigned CYC_W   = cnt_width(CYC_MAX);

  if ((N_REP % 2) == 0 || N_REP < MIN_N_REP) begin : g_err_n_rep
    $error("puf_race_sampler: N_REP must be odd and >= 1");
  end
  if (SETTLE_CYCLES < MIN_SETTLE_CYCLES) begin : g_err_settle
    $error("puf_race_sampler: SETTLE_CYCLES must be >= 4");
  end
  if (RELAX_CYCLES < MIN_RELAX_CYCLES) begin : g_err_relax
    $error("puf_race_sampler: RELAX_CYCLES must be >= 1");
  end

  logic [ST_W-1:0]     r_state;
  logic [CYC_W-1:0]    r_cyc;
  logic [CNT_W-1:0]    r_rep;
  logic [CNT_W-1:0]    r_ones;
  logic [C_LENGTH-1:0] r_challenge;
  logic                r_chal_ready;
  logic                r_ipulse;
  logic                r_resp_valid;
  logic                r_resp_bit;
  logic [CNT_W-1:0]    r_resp_ones;
  logic                r_resp_stable;
  logic                r_busy;

  logic [ST_W-1:0]     w_state_nxt;
  logic [CYC_W-1:0]    w_cyc_nxt;
  logic [CNT_W-1:0]    w_rep_nxt;
  logic [CNT_W-1:0]    w_ones_nxt;
  logic [C_LENGTH-1:0] w_chal_nxt;
  logic                w_last_fire;
  logic                w_sync;

  sync_2ff u_sync_arb (
    .clk     (clk),
    .rst     (rst),
    .i_async (arb_in),
    .o_sync  (w_sync)
  );

  // Next-state: RELAX/FIRE phases timed by r_cyc, firings counted by r_rep.
  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc;
    w_rep_nxt   = r_rep;
    w_ones_nxt  = r_ones;
    w_chal_nxt  = r_challenge;
    w_last_fire = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (chal_valid) begin
          w_state_nxt = ST_RELAX;
          w_chal_nxt  = chal_data;
          w_cyc_nxt   = '0;
          w_rep_nxt   = '0;
          w_ones_nxt  = '0;
        end
      end
      ST_RELAX: begin
        if (r_cyc == CYC_W'(RELAX_CYCLES - 1)) begin
          w_state_nxt = ST_FIRE;
          w_cyc_nxt   = '0;
        end else begin
          w_cyc_nxt = r_cyc + CYC_W'(1);
        end
      end
      ST_FIRE: begin
        if (r_cyc == CYC_W'(SETTLE_CYCLES - 1)) begin
          w_last_fire = 1'b1;
          w_cyc_nxt   = '0;
          w_ones_nxt  = r_ones + CNT_W'(w_sync);
          w_rep_nxt   = r_rep + CNT_W'(1);
          w_state_nxt = (w_rep_nxt == CNT_W'(N_REP)) ? ST_DONE : ST_RELAX;
        end else begin
          w_cyc_nxt = r_cyc + CYC_W'(1);
        end
      end
      ST_DONE: begin
        if (resp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs; outputs track the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cyc         <= '0;
      r_rep         <= '0;
      r_ones        <= '0;
      r_challenge   <= '0;
      r_chal_ready  <= 1'b1;
      r_ipulse      <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_bit    <= 1'b0;
      r_resp_ones   <= '0;
      r_resp_stable <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cyc        <= w_cyc_nxt;
      r_rep        <= w_rep_nxt;
      r_ones       <= w_ones_nxt;
      r_challenge  <= w_chal_nxt;
      r_chal_ready <= (w_state_nxt == ST_IDLE);
      r_ipulse     <= (w_state_nxt == ST_FIRE);
      r_resp_valid <= (w_state_nxt == ST_DONE);
      r_busy       <= (w_state_nxt != ST_IDLE);
      if (w_last_fire && (w_state_nxt == ST_DONE)) begin
        r_resp_bit    <= (w_ones_nxt > CNT_W'(N_REP / 2));
        r_resp_ones   <= w_ones_nxt;
        r_resp_stable <= (w_ones_nxt == '0) || (w_ones_nxt == CNT_W'(N_REP));
      end
    end
  end

  assign chal_ready  = r_chal_ready;
  assign challenge   = r_challenge;
  assign ipulse      = r_ipulse;
  assign resp_valid  = r_resp_valid;
  assign resp_bit    = r_resp_bit;
  assign resp_ones   = r_resp_ones;
  assign resp_stable = r_resp_stable;
  assign busy        = r_busy;

endmodule

// File: tb/tb_puf_race_sampler.sv
// Directed bench for puf_race_sampler with N_REP=3, SETTLE_CYCLES=4, RELAX_CYCLES=2.
module tb_puf_race_sampler;

  localparam int unsigned C_LENGTH = 32;
  localparam int unsigned N_REP    = 3;
  localparam int unsigned SETTLE   = 4;
  localparam int unsigned RELAX    = 2;
  localparam int unsigned PERIOD   = SETTLE + RELAX;
  localparam int unsigned LATENCY  = N_REP * PERIOD;

  logic                clk;
  logic                rst;
  logic                chal_valid;
  logic                chal_ready;
  logic [C_LENGTH-1:0] chal_data;
  logic [C_LENGTH-1:0] challenge;
  logic                ipulse;
  logic                arb_in;
  logic                resp_valid;
  logic                resp_ready;
  logic                resp_bit;
  logic [1:0]          resp_ones;
  logic                resp_stable;
  logic                busy;

  int n_cmp = 0;
  int n_err = 0;
  int viol  = 0;
  logic                prev_ip   = 1'b0;
  logic [C_LENGTH-1:0] prev_chal = '0;

  puf_race_sampler #(
    .C_LENGTH      (C_LENGTH),
    .N_REP         (N_REP),
    .SETTLE_CYCLES (SETTLE),
    .RELAX_CYCLES  (RELAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .chal_valid  (chal_valid),
    .chal_ready  (chal_ready),
    .chal_data   (chal_data),
    .challenge   (challenge),
    .ipulse      (ipulse),
    .arb_in      (arb_in),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_bit    (resp_bit),
    .resp_ones   (resp_ones),
    .resp_stable (resp_stable),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Challenge must never move while the launch pulse is held high.
  always @(negedge clk) begin
    if (ipulse && prev_ip && (challenge !== prev_chal)) viol++;
    prev_ip   = ipulse;
    prev_chal = challenge;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept d, drive arb_in per firing (arb[0] = firing 1), end at negedge after resp_valid rises.
  task automatic run_eval(input string tag, input logic [31:0] d, input logic [2:0] arb,
                          input logic exp_bit, input int exp_ones, input logic exp_stable);
    logic [LATENCY-1:0] obs_pat;
    logic [LATENCY-1:0] exp_pat;
    logic early_rv;
    logic chal_ok;
    early_rv = 1'b0;
    chal_ok  = 1'b1;
    chal_valid = 1'b1;
    chal_data  = d;
    @(posedge clk);
    @(negedge clk);
    chal_valid = 1'b0;
    chal_data  = ~d;
    check({tag, "_chal_ready_busy"}, {30'd0, chal_ready, busy}, 32'h1);
    for (int i = 0; i < int'(LATENCY); i++) begin
      if ((i % PERIOD) == 0) arb_in = arb[i / PERIOD];
      obs_pat[i] = ipulse;
      exp_pat[i] = ((i % PERIOD) >= RELAX);
      if (resp_valid) early_rv = 1'b1;
      if (challenge !== d) chal_ok = 1'b0;
      @(negedge clk);
    end
    check({tag, "_ipulse_pattern"}, 32'(obs_pat), 32'(exp_pat));
    check({tag, "_no_early_valid"}, 32'(early_rv), 32'h0);
    check({tag, "_challenge_held"}, 32'(chal_ok), 32'h1);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'h1);
    check({tag, "_resp_bit"}, 32'(resp_bit), 32'(exp_bit));
    check({tag, "_resp_ones"}, 32'(resp_ones), 32'(exp_ones));
    check({tag, "_resp_stable"}, 32'(resp_stable), 32'(exp_stable));
  endtask

  task automatic release_resp(input string tag, input int exp_ones);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_after_hs_valid_ready_busy"}, {29'd0, resp_valid, chal_ready, busy}, 32'h2);
    check({tag, "_ones_held"}, 32'(resp_ones), 32'(exp_ones));
  endtask

  initial begin
    logic bp_ok;
    logic rv_seen;
    int t_rv1, t_rv2, t_acc2, n_rise;
    logic prev_rv;

    rst = 1'b1; chal_valid = 1'b0; chal_data = '0; arb_in = 1'b0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_outputs", {25'd0, ipulse, resp_valid, resp_bit, resp_ones, resp_stable, busy},
          32'h0);
    check("reset_chal_ready", 32'(chal_ready), 32'h1);
    check("reset_challenge", challenge, 32'h0);

    run_eval("stable1", 32'hA5A5_0F0F, 3'b111, 1'b1, 3, 1'b1);
    release_resp("stable1", 3);

    run_eval("maj101", 32'h1234_5678, 3'b101, 1'b1, 2, 1'b0);
    release_resp("maj101", 2);

    // Backpressure: response held, new challenge offers ignored.
    run_eval("maj010", 32'hCAFE_0001, 3'b010, 1'b0, 1, 1'b0);
    bp_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chal_valid = (i == 3);
      chal_data  = 32'hDEAD_BEEF;
      @(negedge clk);
      if (!resp_valid || resp_bit || resp_ones != 2'd1 || resp_stable || chal_ready ||
          challenge !== 32'hCAFE_0001) bp_ok = 1'b0;
    end
    chal_valid = 1'b0;
    check("backpressure_hold", 32'(bp_ok), 32'h1);
    check("backpressure_challenge", challenge, 32'hCAFE_0001);
    release_resp("backpressure", 1);

    // Reset during the 2nd FIRE cycle of firing 2.
    arb_in = 1'b1;
    chal_valid = 1'b1;
    chal_data  = 32'h5555_AAAA;
    @(posedge clk);
    @(negedge clk);
    chal_valid = 1'b0;
    repeat (PERIOD + RELAX + 1) @(negedge clk);
    check("midfire_ipulse_high", 32'(ipulse), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midfire_after_rst", {28'd0, ipulse, resp_valid, busy, chal_ready}, 32'h1);
    rv_seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (resp_valid) rv_seen = 1'b1;
    end
    check("midfire_no_response", 32'(rv_seen), 32'h0);
    run_eval("fresh000", 32'h0F0F_F0F0, 3'b000, 1'b0, 0, 1'b1);
    release_resp("fresh000", 0);

    // Back-to-back with resp_ready tied high.
    resp_ready = 1'b1;
    arb_in     = 1'b1;
    chal_valid = 1'b1;
    chal_data  = 32'h1111_1111;
    @(posedge clk);
    @(negedge clk);
    chal_data = 32'h2222_2222;
    t_rv1 = -1; t_rv2 = -1; t_acc2 = -1; n_rise = 0; prev_rv = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (resp_valid && !prev_rv) begin
        n_rise++;
        if (n_rise == 1) t_rv1 = n;
        else if (n_rise == 2) t_rv2 = n;
      end
      prev_rv = resp_valid;
      if (t_acc2 < 0 && challenge === 32'h2222_2222) begin
        t_acc2 = n;
        chal_valid = 1'b0;
      end
    end
    chal_valid = 1'b0;
    resp_ready = 1'b0;
    check("b2b_first_resp_cycle", 32'(t_rv1), 32'(LATENCY));
    check("b2b_second_accept_cycle", 32'(t_acc2), 32'(LATENCY + 2));
    check("b2b_second_resp_cycle", 32'(t_rv2), 32'(2 * LATENCY + 2));
    check("b2b_response_count", 32'(n_rise), 32'h2);
    check("b2b_final", {29'd0, resp_ones, resp_stable}, 32'h7);
    check("challenge_stable_while_ipulse", 32'(viol), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/puf_race_sampler.md
Name: puf_race_sampler

Overview:
- Drives the launch side of the arbiter-PUF delay line and reads back its response.
- Accepts a challenge over a valid/ready handshake and holds it on the line's challenge bus.
- Fires the launch pulse N_REP times, with a relax gap between firings.
- Samples the arbiter latch output once per firing through a synchronizer, majority-votes the samples, and returns one response bit plus a stability flag over a valid/ready handshake.

Parameters:
C_LENGTH, 32, challenge width; equals the delay-line stage count
N_REP, 15, firings per challenge; must be odd and >= 1
SETTLE_CYCLES, 8, cycles ipulse is held high per firing; must be >= 4
RELAX_CYCLES, 8, cycles ipulse is held low before each firing; must be >= 1

Ports:
clk  in  1  system clock
rst  in  1  reset
chal_valid  in  1  challenge offer
chal_ready  out  1  block can accept a challenge
chal_data  in  C_LENGTH  challenge to evaluate
challenge  out  C_LENGTH  registered challenge bus to the delay line
ipulse  out  1  launch pulse to the delay line
arb_in  in  1  arbiter latch output; asynchronous to clk
resp_valid  out  1  response available
resp_ready  in  1  response consumed
resp_bit  out  1  majority response
resp_ones  out  $clog2(N_REP+1)  count of samples equal to 1
resp_stable  out  1  all N_REP samples agreed
busy  out  1  evaluation in progress (state not IDLE)

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; challenge=0; ipulse=0; resp_valid=0; resp_bit=0; resp_ones=0; resp_stable=0; busy=0; rep and cycle counters=0; synchronizer flops=0.
- Reset mid-operation: on the next edge, ipulse drops to 0 and the block returns to IDLE. Any partial vote is discarded and no response is emitted.
- chal_ready=1 only in IDLE.
- Accept: chal_valid & chal_ready at an edge. On that edge, challenge<=chal_data, the ones counter is cleared, and state goes to RELAX.
- challenge is stable from accept until the next accept. It never changes while ipulse=1.
- States:
  - IDLE: ipulse=0. Leaves on accept.
  - RELAX: ipulse=0 for exactly RELAX_CYCLES cycles, then FIRE.
  - FIRE: ipulse=1 for exactly SETTLE_CYCLES cycles. On the last FIRE cycle, the synchronized arb_in is sampled and added to the ones counter, and rep increments. Next state is DONE if rep reaches N_REP, else RELAX.
  - DONE: ipulse=0; resp_valid=1; resp_bit=(ones > N_REP/2); resp_ones=ones; resp_stable=(ones==0 or ones==N_REP). Leaves to IDLE on resp_valid & resp_ready.
- Response outputs hold steady while resp_valid=1 and stay at their last values after the handshake.
- Synchronizer: arb_in passes through 2 flops. The sample taken on the last FIRE cycle reflects arb_in as of at least 2 edges earlier; this is why SETTLE_CYCLES >= 4.
- Latency: resp_valid rises N_REP*(RELAX_CYCLES+SETTLE_CYCLES) edges after the accept edge.
- Back-to-back: chal_ready reasserts on the cycle after the resp handshake. There is no overlap between evaluations.
- chal_valid outside IDLE is ignored. chal_data is not captured.
- Width rule: the ones counter is $clog2(N_REP+1) bits and never wraps, since at most N_REP samples are counted.
- Parameter checks: N_REP even, SETTLE_CYCLES < 4, or RELAX_CYCLES = 0 each raise an elaboration-time $error.

Decomposition:
- Package puf_pkg holds:
  - the state enum (IDLE, RELAX, FIRE, DONE);
  - a shared $clog2-based width constant for the counters;
  - the parameter legality constants.
- Sub-module sync_2ff: 1-bit, two-flop synchronizer with synchronous reset. It is reused for arb_in and for any later asynchronous PUF signals.

Test Plan:
- All scenarios use N_REP=3, SETTLE_CYCLES=4, RELAX_CYCLES=2 unless noted.
- Reset: hold rst 3 cycles -> all outputs 0, chal_ready=1, busy=0.
- Stable 1: accept chal_data=32'hA5A5_0F0F with arb_in held 1 -> challenge=32'hA5A5_0F0F; ipulse pattern per firing is 2 low then 4 high, repeated 3 times; resp_valid rises 18 edges after accept with resp_bit=1, resp_ones=3, resp_stable=1.
- Majority/unstable: arb_in=1 during firings 1 and 3 and 0 during firing 2 -> resp_bit=1, resp_ones=2, resp_stable=0. With arb_in=0,1,0 -> resp_bit=0, resp_ones=1, resp_stable=0.
- Response backpressure: hold resp_ready=0 for 10 cycles after resp_valid -> outputs unchanged and chal_ready=0; drive a chal_valid pulse with new data -> challenge unchanged. Then set resp_ready=1 -> IDLE and chal_ready=1 on the next cycle.
- Reset mid-FIRE: assert rst during the 2nd FIRE cycle of firing 2 -> ipulse=0 on the next edge, resp_valid never rises, and the next challenge yields a correct fresh count (resp_ones excludes earlier samples).
- Back-to-back: 2 challenges with resp_ready tied 1 -> 2 responses; the second accept happens 1 cycle after the first response handshake; challenge never toggles while ipulse=1 (assertion).
